// File: rtl/bp_me_pkg.sv
// rtl/bp_me_pkg.sv - shared FSM and error-code types for the CCE message monitor
package bp_me_pkg;

  typedef enum logic [1:0] {
    e_run    = 2'd0,
    e_frozen = 2'd1,
    e_error  = 2'd2
  } mon_state_e;

  typedef enum logic [1:0] {
    e_err_none      = 2'b00,
    e_err_overflow  = 2'b01,
    e_err_underflow = 2'b10
  } mon_err_e;

endpackage

// File: rtl/bp_me_cce_msg_monitor_fifo.sv
// rtl/bp_me_cce_msg_monitor_fifo.sv - valid->yumi trace FIFO, power-of-two depth
// A full FIFO still accepts a write in the cycle its head is consumed.
module bp_me_cce_msg_monitor_fifo #(
  parameter int width_p = 19,
  parameter int els_p   = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);
  localparam int lg_els_lp = $clog2(els_p);
  localparam logic [lg_els_lp-1:0] ptr_one_lp = lg_els_lp'(1);
  localparam logic [lg_els_lp:0]   cnt_one_lp = (lg_els_lp+1)'(1);
  localparam logic [lg_els_lp:0]   cnt_full_lp = (lg_els_lp+1)'(els_p);

  logic [width_p-1:0]   mem_q [els_p];
  logic [lg_els_lp-1:0] wptr_q, rptr_q;
  logic [lg_els_lp:0]   cnt_q;
  logic                 enq, deq;

  assign v_o     = (cnt_q != '0);
  assign ready_o = (cnt_q != cnt_full_lp) | yumi_i;
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;
  assign data_o  = mem_q[rptr_q];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clear_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (enq) wptr_q <= wptr_q + ptr_one_lp;
      if (deq) rptr_q <= rptr_q + ptr_one_lp;
      case ({enq, deq})
        2'b10:   cnt_q <= cnt_q + cnt_one_lp;
        2'b01:   cnt_q <= cnt_q - cnt_one_lp;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/bp_me_cce_msg_monitor.sv
// rtl/bp_me_cce_msg_monitor.sv - per-channel fire counters, outstanding mem tracker, trace
// Trace FIFO and drop counter exist only when BP_ME_CCE_MON_TRACE_FIFO_EN is defined.
module bp_me_cce_msg_monitor
  import bp_me_pkg::*;
#(
  parameter int num_chan_p        = 5,
  parameter int cnt_width_p       = 32,
  parameter int max_outstanding_p = 16,
  parameter int mem_cmd_chan_p    = 3,
  parameter int mem_resp_chan_p   = 4,
  parameter int trace_els_p       = 8,
  parameter int ts_width_p        = 16
) (
  input  logic                                         clk_i,
  input  logic                                         reset_n_i,
  input  logic                                         freeze_i,
  input  logic                                         clear_i,
  input  logic [num_chan_p-1:0]                        v_i,
  input  logic [num_chan_p-1:0]                        hs_i,
  output logic [num_chan_p*cnt_width_p-1:0]            count_o,
  output logic [$clog2(max_outstanding_p+1)-1:0]       outstanding_o,
  output logic                                         error_o,
  output logic [1:0]                                   err_code_o,
  output logic                                         trace_v_o,
  output logic [$clog2(num_chan_p)+ts_width_p-1:0]     trace_data_o,
  input  logic                                         trace_yumi_i,
  output logic [cnt_width_p-1:0]                       drop_o
);
  localparam int out_w_lp = $clog2(max_outstanding_p+1);
  localparam logic [cnt_width_p-1:0] cnt_one_lp = cnt_width_p'(1);
  localparam logic [out_w_lp-1:0]    out_one_lp = out_w_lp'(1);
  localparam logic [out_w_lp-1:0]    out_max_lp = out_w_lp'(max_outstanding_p);
  localparam logic [ts_width_p-1:0]  ts_one_lp  = ts_width_p'(1);

  logic [num_chan_p-1:0]                  fire;
  logic                                   cmd_only, resp_only, ovf, udf;
  logic [num_chan_p-1:0][cnt_width_p-1:0] cnt_q, cnt_d;
  logic [ts_width_p-1:0]                  ts_q;
  logic [out_w_lp-1:0]                    out_q, out_d;
  mon_state_e                             state_q, state_d;
  mon_err_e                               err_q, err_d;

  assign fire      = v_i & hs_i;
  assign cmd_only  = fire[mem_cmd_chan_p] & ~fire[mem_resp_chan_p];
  assign resp_only = fire[mem_resp_chan_p] & ~fire[mem_cmd_chan_p];

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (!freeze_i) begin
      for (int c = 0; c < num_chan_p; c++) begin
        if (fire[c] && (cnt_q[c] != '1)) cnt_d[c] = cnt_q[c] + cnt_one_lp;
      end
    end
  end

  // Outstanding saturates at both ends; the first bound violation latches the cause.
  always_comb begin
    out_d   = out_q;
    state_d = state_q;
    err_d   = err_q;
    ovf     = 1'b0;
    udf     = 1'b0;
    if (clear_i) begin
      out_d   = '0;
      state_d = e_run;
      err_d   = e_err_none;
    end else begin
      if (!freeze_i) begin
        if (cmd_only) begin
          if (out_q == out_max_lp) ovf = 1'b1;
          else                     out_d = out_q + out_one_lp;
        end else if (resp_only) begin
          if (out_q == '0) udf = 1'b1;
          else             out_d = out_q - out_one_lp;
        end
      end
      if (state_q != e_error) begin
        if (ovf) begin
          state_d = e_error;
          err_d   = e_err_overflow;
        end else if (udf) begin
          state_d = e_error;
          err_d   = e_err_underflow;
        end else begin
          state_d = freeze_i ? e_frozen : e_run;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q   <= '0;
      ts_q    <= '0;
      out_q   <= '0;
      state_q <= e_run;
      err_q   <= e_err_none;
    end else begin
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      state_q <= state_d;
      err_q   <= err_d;
      if (!freeze_i) ts_q <= ts_q + ts_one_lp;
    end
  end

  assign count_o       = cnt_q;
  assign outstanding_o = out_q;
  assign error_o       = (state_q == e_error);
  assign err_code_o    = err_q;

`ifdef BP_ME_CCE_MON_TRACE_FIFO_EN
  localparam int lg_chan_lp = $clog2(num_chan_p);
  localparam int nf_w_lp    = lg_chan_lp + 1;
  localparam int drop_w_lp  = cnt_width_p + 1;

  logic [lg_chan_lp-1:0]  first_idx;
  logic [nf_w_lp-1:0]     n_fire;
  logic                   fifo_ready, enq, deq_yumi;
  logic [cnt_width_p-1:0] drop_q, drop_d;
  logic [drop_w_lp-1:0]   drop_sum;

  always_comb begin
    first_idx = '0;
    n_fire    = '0;
    for (int c = num_chan_p-1; c >= 0; c--) begin
      if (fire[c]) first_idx = lg_chan_lp'(c);
    end
    for (int c = 0; c < num_chan_p; c++) begin
      n_fire = n_fire + nf_w_lp'(fire[c]);
    end
  end

  assign enq      = ~freeze_i & ~clear_i & (|fire) & fifo_ready;
  assign deq_yumi = trace_yumi_i & trace_v_o;
  // Every firing channel that did not make it into the FIFO is a drop.
  assign drop_sum = {1'b0, drop_q} + drop_w_lp'(n_fire - nf_w_lp'(enq));

  always_comb begin
    drop_d = drop_q;
    if (clear_i)        drop_d = '0;
    else if (!freeze_i) drop_d = drop_sum[cnt_width_p] ? '1 : drop_sum[cnt_width_p-1:0];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) drop_q <= '0;
    else            drop_q <= drop_d;
  end

  bp_me_cce_msg_monitor_fifo #(
    .width_p(lg_chan_lp + ts_width_p),
    .els_p  (trace_els_p)
  ) u_fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .clear_i  (clear_i),
    .v_i      (enq),
    .data_i   ({first_idx, ts_q}),
    .ready_o  (fifo_ready),
    .v_o      (trace_v_o),
    .data_o   (trace_data_o),
    .yumi_i   (deq_yumi)
  );

  assign drop_o = drop_q;
`else
  logic unused_trace;
  assign unused_trace = (^{trace_yumi_i, ts_q}) ^ (trace_els_p > 0);
  assign trace_v_o    = 1'b0;
  assign trace_data_o = '0;
  assign drop_o       = '0;
`endif

endmodule

// File: tb/tb_bp_me_cce_msg_monitor.sv
// tb/tb_bp_me_cce_msg_monitor.sv - directed and randomized checks against a behavioural model
module tb_bp_me_cce_msg_monitor;
  localparam int NC   = 5;
  localparam int CW   = 32;
  localparam int MAXO = 16;
  localparam int CMD  = 3;
  localparam int RESP = 4;
  localparam int ELS  = 8;
  localparam int TSW  = 16;
`ifdef BP_ME_CCE_MON_TRACE_FIFO_EN
  localparam bit TRACE_EN = 1'b1;
`else
  localparam bit TRACE_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          freeze = 1'b0;
  logic          clear = 1'b0;
  logic          yumi = 1'b0;
  logic [NC-1:0] v = '0;
  logic [NC-1:0] hs = '0;
  logic [NC*CW-1:0] count;
  logic [4:0]    outst;
  logic          error;
  logic [1:0]    code;
  logic          tv;
  logic [18:0]   tdata;
  logic [CW-1:0] drop;

  always #5 clk = ~clk;

  bp_me_cce_msg_monitor #(
    .num_chan_p(NC), .cnt_width_p(CW), .max_outstanding_p(MAXO),
    .mem_cmd_chan_p(CMD), .mem_resp_chan_p(RESP), .trace_els_p(ELS), .ts_width_p(TSW)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .freeze_i(freeze), .clear_i(clear),
    .v_i(v), .hs_i(hs), .count_o(count), .outstanding_o(outst),
    .error_o(error), .err_code_o(code), .trace_v_o(tv), .trace_data_o(tdata),
    .trace_yumi_i(yumi), .drop_o(drop)
  );

  int n_pass = 0;
  int n_total = 0;

  longint m_cnt[NC];
  int     m_out, m_err, m_ts;
  longint m_drop;
  int     m_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) m_cnt[c] = 0;
    m_out = 0; m_err = 0; m_ts = 0; m_drop = 0;
    m_q.delete();
  endtask

  task automatic model_update();
    logic [NC-1:0] f;
    int nf, lo;
    bit take;
    f = v & hs; nf = 0; lo = -1;
    if (clear) begin
      for (int c = 0; c < NC; c++) m_cnt[c] = 0;
      m_out = 0; m_err = 0; m_drop = 0;
      m_q.delete();
    end else begin
      if (!freeze) begin
        for (int c = 0; c < NC; c++) begin
          if (f[c]) begin
            nf++;
            if (lo < 0) lo = c;
            if (m_cnt[c] < 64'hFFFF_FFFF) m_cnt[c]++;
          end
        end
        if (f[CMD] && !f[RESP]) begin
          if (m_out == MAXO) begin if (m_err == 0) m_err = 1; end
          else m_out++;
        end else if (f[RESP] && !f[CMD]) begin
          if (m_out == 0) begin if (m_err == 0) m_err = 2; end
          else m_out--;
        end
        if (TRACE_EN && nf > 0) begin
          take = (m_q.size() < ELS) || yumi;
          if (take) m_q.push_back(lo * 65536 + m_ts);
          m_drop += nf - (take ? 1 : 0);
          if (m_drop > 64'hFFFF_FFFF) m_drop = 64'hFFFF_FFFF;
        end
      end
      if (yumi) void'(m_q.pop_front());
    end
    if (!freeze) m_ts = (m_ts + 1) % 65536;
  endtask

  task automatic check_all(input string ph);
    for (int c = 0; c < NC; c++)
      chk($sformatf("%s.count%0d", ph, c), 64'(count[c*CW +: CW]), 64'(m_cnt[c]));
    chk($sformatf("%s.outstanding", ph), 64'(outst), 64'(m_out));
    chk($sformatf("%s.error", ph), 64'(error), 64'(m_err != 0));
    chk($sformatf("%s.err_code", ph), 64'(code), 64'(m_err));
    chk($sformatf("%s.trace_v", ph), 64'(tv), 64'(m_q.size() > 0));
    chk($sformatf("%s.drop", ph), 64'(drop), 64'(m_drop));
    if (m_q.size() > 0 || !TRACE_EN)
      chk($sformatf("%s.trace_data", ph), 64'(tdata), 64'((m_q.size() > 0) ? m_q[0] : 0));
  endtask

  task automatic step(input logic [NC-1:0] sv, input logic [NC-1:0] shs,
                      input logic sf, input logic sc, input logic sy, input string ph);
    v = sv; hs = shs; freeze = sf; clear = sc;
    yumi = sy && (m_q.size() > 0);
    model_update();
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  initial begin
    model_reset();
    #3;
    check_all("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Channel counting, including a valid without handshake.
    repeat (3) step(5'b00001, 5'b00001, 0, 0, 0, "ch0");
    step(5'b00100, 5'b00100, 0, 0, 0, "ch2");
    step(5'b00010, 5'b00000, 0, 0, 0, "no_hs");
    chk("r032.ch0", 64'(count[0 +: CW]), 64'd3);
    chk("r032.ch2", 64'(count[2*CW +: CW]), 64'd1);
    chk("r032.ch1", 64'(count[1*CW +: CW]), 64'd0);
    repeat (6) step('0, '0, 0, 0, 1, "drain");

    // Overflow, then clear beating simultaneous fire and freeze.
    repeat (17) step(5'b01000, 5'b01000, 0, 0, 0, "cmd");
    chk("r033.outstanding", 64'(outst), 64'd16);
    chk("r033.error", 64'(error), 64'd1);
    chk("r033.code", 64'(code), 64'd1);
    step('1, '1, 1, 1, 0, "clr_prio");
    chk("r033.clr_outstanding", 64'(outst), 64'd0);
    chk("r033.clr_error", 64'(error), 64'd0);
    chk("r033.clr_count3", 64'(count[3*CW +: CW]), 64'd0);

    // Underflow.
    step(5'b10000, 5'b10000, 0, 0, 0, "resp0");
    chk("r034.code", 64'(code), 64'd2);
    chk("r034.outstanding", 64'(outst), 64'd0);
    step('0, '0, 0, 1, 0, "clr2");

    // Freeze with firing channels, then a yumi-only cycle while frozen.
    step(5'b00001, 5'b00001, 0, 0, 0, "pre_frz");
    repeat (4) step(5'b01011, 5'b01111, 1, 0, 0, "frz");
    step('0, '0, 1, 0, 1, "frz_yumi");
    step(5'b00100, 5'b00100, 0, 0, 0, "post_frz");
    repeat (2) step('0, '0, 0, 0, 1, "drain2");

    // Asynchronous reset in mid-cycle.
    step(5'b00011, 5'b00011, 0, 0, 0, "pre_rst");
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    reset_n = 1'b1;

    // Two simultaneous fires at timestamp 5.
    repeat (5) step('0, '0, 0, 0, 0, "idle");
    step(5'b01010, 5'b01010, 0, 0, 0, "dual");
    chk("r035.entry", 64'(tdata), TRACE_EN ? 64'h10005 : 64'd0);
    chk("r035.drop", 64'(drop), TRACE_EN ? 64'd1 : 64'd0);

    // FIFO full behaviour.
    step('0, '0, 0, 1, 0, "clr3");
    repeat (9) step(5'b00001, 5'b00001, 0, 0, 0, "fill");
    chk("r036.drop", 64'(drop), TRACE_EN ? 64'd1 : 64'd0);
    step(5'b00001, 5'b00001, 0, 0, 1, "full_yumi");
    chk("r036.drop_same", 64'(drop), TRACE_EN ? 64'd1 : 64'd0);
    chk("r036.trace_v", 64'(tv), TRACE_EN ? 64'd1 : 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [NC-1:0] rv, rh;
      rv = NC'($urandom);
      rh = NC'($urandom) | NC'($urandom);
      step(rv, rh, ($urandom_range(0, 9) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 2) != 0), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bp_me_cce_msg_monitor.md
BP_ME_CCE_MSG_MONITOR -- requirements
Module: bp_me_cce_msg_monitor

Interface
REQ-001 Parameter num_chan_p, default 5, meaning number of monitored ready&valid/valid->yumi channels.
REQ-002 Parameter cnt_width_p, default 32, meaning width of each per-channel event counter.
REQ-003 Parameter max_outstanding_p, default 16, meaning legal outstanding mem_cmd-minus-mem_resp bound.
REQ-004 Parameters mem_cmd_chan_p (default 3) and mem_resp_chan_p (default 4), meaning channel indices of mem cmd / mem resp.
REQ-005 Parameter trace_els_p, default 8, meaning trace FIFO depth, power of two; ts_width_p, default 16, meaning timestamp width.
REQ-006 clk_i  input  1  sole clock; all state on posedge.
REQ-007 reset_n_i  input  1  asynchronous, active-low reset.
REQ-008 freeze_i  input  1  hold all counters and FIFO writes while high.
REQ-009 clear_i  input  1  synchronous clear of counters, error state and FIFO.
REQ-010 v_i / hs_i  input  num_chan_p each  channel valid and ready-or-yumi; fire[c] = v_i[c] & hs_i[c].
REQ-011 count_o  output  num_chan_p*cnt_width_p  per-channel fire counts, channel c at slice c.
REQ-012 outstanding_o  output  clog2(max_outstanding_p+1)  current outstanding mem commands.
REQ-013 error_o  output  1, err_code_o  output  2  sticky error flag and cause (01 overflow, 10 underflow).
REQ-014 trace_v_o  output  1, trace_data_o  output  clog2(num_chan_p)+ts_width_p, trace_yumi_i  input  1  valid->yumi trace read port; drop_o  output  cnt_width_p  dropped-event count.

Function
REQ-015 Free-running ts_width_p cycle timestamp SHALL increment every cycle not frozen, wrapping to 0.
REQ-016 count_o[c] SHALL increment by 1 in the cycle after fire[c], saturating at all-ones.
REQ-017 outstanding SHALL +1 on mem_cmd fire only, -1 on mem_resp fire only, unchanged when both or neither fire.
REQ-018 FSM states e_run, e_frozen, e_error; e_run->e_frozen while freeze_i, back when freeze_i low.
REQ-019 e_run->e_error when outstanding would exceed max_outstanding_p (code 01) or go below 0 (code 10); value SHALL saturate, not wrap.
REQ-020 e_error SHALL be sticky: counters keep counting, error_o=1, exit only via clear_i or reset to e_run.
REQ-021 Trace: at most one enqueue per cycle, lowest-indexed firing channel, entry {channel index, timestamp}.
REQ-022 Each additional simultaneous fire, and any fire when FIFO full without same-cycle yumi, SHALL increment drop_o (saturating).
REQ-023 Full FIFO with same-cycle yumi SHALL accept the enqueue; trace_yumi_i SHALL be asserted only when trace_v_o=1.
REQ-024 Write-to-read latency: entry visible on trace_v_o the cycle after fire.
REQ-025 clear_i SHALL take priority over fire and freeze in the same cycle; freeze_i SHALL block counting and enqueue but not yumi.

Reset
REQ-026 While reset_n_i low: count_o, outstanding_o, error_o, err_code_o, drop_o, timestamp = 0, trace_v_o = 0, FSM = e_run.
REQ-027 Reset asserted mid-operation SHALL discard FIFO contents immediately, no clock required.

Configuration
REQ-028 Macro BP_ME_CCE_MON_TRACE_FIFO_EN defined: trace FIFO, drop_o and trace port per REQ-021..024.
REQ-029 Macro undefined: no FIFO storage; trace_v_o, trace_data_o, drop_o tied 0; trace_yumi_i ignored; counters/FSM unchanged.

Structure
REQ-030 FSM state enum and error-code enum SHALL live in bp_me_pkg.
REQ-031 Trace FIFO SHALL be one sub-module, bp_me_cce_msg_monitor_fifo (valid->yumi, trace_els_p deep).

Verification
REQ-032 fire ch0 three cycles, ch2 once -> count_o ch0=3, ch2=1, others 0.
REQ-033 17 mem_cmd fires, no resp, max_outstanding_p=16 -> outstanding_o=16, error_o=1, err_code_o=01; clear_i -> all 0.
REQ-034 mem_resp fire at outstanding 0 -> err_code_o=10, outstanding_o stays 0.
REQ-035 ch1 and ch3 fire same cycle at ts=5 -> entry {1,5}, drop_o=1.
REQ-036 9 single fires, no yumi, depth 8 -> 8 entries, drop_o=1; yumi with fire when full -> enqueued, drop_o unchanged.
REQ-037 freeze_i high 4 cycles with fires -> counts and timestamp unchanged; reset_n_i low mid-run -> all outputs 0 asynchronously.
